sm83_regfile: RTL and testbench

//  SM83 architectural register file and ALU writeback stage: A,F,B,C,D,E,H,L,SP,PC.

---
 rtl/sm83_regfile.sv | 147 ++++++++++++++
 tb/tb_sm83_regfile.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_regfile.sv
// SM83 architectural register file with ALU writeback, flag merge,
// 16-bit increment/decrement unit for BC/DE/HL/SP and the fetch PC.
// Byte slots: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A.
// The F slot keeps its low nibble at zero at all times.
module sm83_regfile #(
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter logic [15:0] SP_RESET = 16'hFFFE,
   parameter bit          BYPASS   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  rd1_sel,
   output logic [7:0]  rd1_data,
   input  logic [2:0]  rd2_sel,
   output logic [7:0]  rd2_data,
   output logic [3:0]  flags,
   input  logic        wr8_en,
   input  logic [2:0]  wr8_sel,
   input  logic [7:0]  wr8_data,
   input  logic        flags_we,
   input  logic [3:0]  flags_mask,
   input  logic [3:0]  flags_in,
   input  logic        wr16_en,
   input  logic [1:0]  wr16_sel,
   input  logic [15:0] wr16_data,
   input  logic        idu_en,
   input  logic [1:0]  idu_sel,
   input  logic        idu_dec,
   input  logic [1:0]  rd16_sel,
   output logic [15:0] rd16_data,
   input  logic        pc_we,
   input  logic [15:0] pc_data,
   input  logic        pc_inc,
   output logic [15:0] pc
);

   logic [7:0][7:0] gpr_r;      // registered byte registers
   logic [7:0][7:0] gpr_n;      // next state of byte registers
   logic [7:0][7:0] wb8_s;      // current registers with only 8-bit and flag writes applied
   logic [15:0]     sp_r;
   logic [15:0]     sp_n;
   logic [15:0]     pc_r;
   logic [15:0]     pc_n;
   logic [15:0]     idu_res_s;
   logic [3:0]      f_base_s;
   logic [3:0]      f_next_s;

   // Pair view: BC/DE/HL are adjacent byte slots (high byte first), 3 is SP.
   function automatic logic [15:0] pair_val(input logic [7:0][7:0] regs,
                                            input logic [15:0]     sp_val,
                                            input logic [1:0]      sel);
      logic [15:0] v;
      case (sel)
         2'd0:    v = {regs[0], regs[1]};
         2'd1:    v = {regs[2], regs[3]};
         2'd2:    v = {regs[4], regs[5]};
         default: v = sp_val;
      endcase
      return v;
   endfunction

   // 8-bit writeback and flag merge; also the forwarding view for read ports.
   always_comb begin
      wb8_s = gpr_r;
      if (wr8_en) begin
         if (wr8_sel == 3'd6) begin
            wb8_s[6] = {wr8_data[7:4], 4'h0};
         end else begin
            wb8_s[wr8_sel] = wr8_data;
         end
      end else begin
         wb8_s = gpr_r;
      end
      f_base_s = wb8_s[6][7:4];
      if (flags_we) begin
         f_next_s = (flags_in & flags_mask) | (f_base_s & ~flags_mask);
      end else begin
         f_next_s = f_base_s;
      end
      wb8_s[6] = {f_next_s, 4'h0};
   end

   // Next register state: IDU lowest priority, then 16-bit write, then 8-bit/flag writes.
   always_comb begin
      gpr_n     = gpr_r;
      sp_n      = sp_r;
      idu_res_s = pair_val(gpr_r, sp_r, idu_sel) + (idu_dec ? 16'hFFFF : 16'h0001);
      if (idu_en) begin
         if (idu_sel == 2'd3) begin
            sp_n = idu_res_s;
         end else begin
            gpr_n[{idu_sel, 1'b0}] = idu_res_s[15:8];
            gpr_n[{idu_sel, 1'b1}] = idu_res_s[7:0];
         end
      end else begin
         sp_n = sp_r;
      end
      if (wr16_en) begin
         if (wr16_sel == 2'd3) begin
            sp_n = wr16_data;
         end else begin
            gpr_n[{wr16_sel, 1'b0}] = wr16_data[15:8];
            gpr_n[{wr16_sel, 1'b1}] = wr16_data[7:0];
         end
      end else begin
         sp_n = sp_n;
      end
      if (wr8_en) begin
         gpr_n[wr8_sel] = wb8_s[wr8_sel];
      end else begin
         gpr_n = gpr_n;
      end
      // F is only ever touched by the 8-bit/flag path.
      gpr_n[6] = wb8_s[6];
   end

   // PC next value: load beats increment, otherwise hold; wraps naturally.
   always_comb begin
      if (pc_we) begin
         pc_n = pc_data;
      end else if (pc_inc) begin
         pc_n = pc_r + 16'h0001;
      end else begin
         pc_n = pc_r;
      end
   end

   // State registers; reset overrides every write on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         gpr_r <= 64'h0;
         sp_r  <= SP_RESET;
         pc_r  <= PC_RESET;
      end else begin
         gpr_r <= gpr_n;
         sp_r  <= sp_n;
         pc_r  <= pc_n;
      end
   end

   assign rd1_data  = BYPASS ? wb8_s[rd1_sel] : gpr_r[rd1_sel];
   assign rd2_data  = BYPASS ? wb8_s[rd2_sel] : gpr_r[rd2_sel];
   assign flags     = BYPASS ? f_next_s : gpr_r[6][7:4];
   assign rd16_data = pair_val(gpr_r, sp_r, rd16_sel);
   assign pc        = pc_r;

endmodule

// File: tb/tb_sm83_regfile.sv
// Scoreboard bench for sm83_regfile: two instances (no forwarding / forwarding)
// share the stimulus; a reference model predicts read-port values per cycle.
module tb_sm83_regfile;

   typedef struct packed {
      logic        rst;
      logic [2:0]  rd1_sel;
      logic [2:0]  rd2_sel;
      logic        wr8_en;
      logic [2:0]  wr8_sel;
      logic [7:0]  wr8_data;
      logic        flags_we;
      logic [3:0]  flags_mask;
      logic [3:0]  flags_in;
      logic        wr16_en;
      logic [1:0]  wr16_sel;
      logic [15:0] wr16_data;
      logic        idu_en;
      logic [1:0]  idu_sel;
      logic        idu_dec;
      logic [1:0]  rd16_sel;
      logic        pc_we;
      logic [15:0] pc_data;
      logic        pc_inc;
   } stim_t;

   typedef struct packed {
      logic        chk;
      logic [7:0]  rd1;
      logic [7:0]  rd2;
      logic [3:0]  flg;
      logic [15:0] rd16;
      logic [15:0] pcv;
      logic [7:0]  rd1b;
      logic [7:0]  rd2b;
      logic [3:0]  flgb;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [2:0]  rd1_sel, rd2_sel, wr8_sel;
   logic        wr8_en, flags_we, wr16_en, idu_en, idu_dec, pc_we, pc_inc;
   logic [7:0]  wr8_data;
   logic [3:0]  flags_mask, flags_in;
   logic [1:0]  wr16_sel, idu_sel, rd16_sel;
   logic [15:0] wr16_data, pc_data;
   logic [7:0]  rd1_a, rd2_a, rd1_b, rd2_b;
   logic [3:0]  flags_a, flags_b;
   logic [15:0] rd16_a, rd16_b, pc_a, pc_b;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: plain architectural registers
   logic [7:0]  m8 [8];
   logic [15:0] m_sp;
   logic [15:0] m_pc;
   bit          m_valid = 1'b0;

   sm83_regfile #(.PC_RESET(16'h0000), .SP_RESET(16'hFFFE), .BYPASS(1'b0)) dut_a (
      .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd1_data(rd1_a), .rd2_sel(rd2_sel),
      .rd2_data(rd2_a), .flags(flags_a), .wr8_en(wr8_en), .wr8_sel(wr8_sel),
      .wr8_data(wr8_data), .flags_we(flags_we), .flags_mask(flags_mask),
      .flags_in(flags_in), .wr16_en(wr16_en), .wr16_sel(wr16_sel),
      .wr16_data(wr16_data), .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec),
      .rd16_sel(rd16_sel), .rd16_data(rd16_a), .pc_we(pc_we), .pc_data(pc_data),
      .pc_inc(pc_inc), .pc(pc_a));

   sm83_regfile #(.PC_RESET(16'h0000), .SP_RESET(16'hFFFE), .BYPASS(1'b1)) dut_b (
      .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd1_data(rd1_b), .rd2_sel(rd2_sel),
      .rd2_data(rd2_b), .flags(flags_b), .wr8_en(wr8_en), .wr8_sel(wr8_sel),
      .wr8_data(wr8_data), .flags_we(flags_we), .flags_mask(flags_mask),
      .flags_in(flags_in), .wr16_en(wr16_en), .wr16_sel(wr16_sel),
      .wr16_data(wr16_data), .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec),
      .rd16_sel(rd16_sel), .rd16_data(rd16_b), .pc_we(pc_we), .pc_data(pc_data),
      .pc_inc(pc_inc), .pc(pc_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mpair(input logic [1:0] sel);
      if (sel == 2'd3) return m_sp;
      return {m8[2 * sel], m8[2 * sel + 1]};
   endfunction

   // What a forwarding read port should show this cycle.
   function automatic logic [7:0] mbyp(input stim_t s, input logic [2:0] sel, input logic [3:0] fnext);
      if (sel == 3'd6) return {fnext, 4'h0};
      if (s.wr8_en && s.wr8_sel == sel) return s.wr8_data;
      return m8[sel];
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   // Drive one cycle, push expected read values, advance the model.
   task automatic apply(input stim_t s);
      exp_t        e;
      logic [3:0]  fbase, fnext;
      logic [7:0]  n8 [8];
      logic [15:0] v;
      rst = s.rst; rd1_sel = s.rd1_sel; rd2_sel = s.rd2_sel;
      wr8_en = s.wr8_en; wr8_sel = s.wr8_sel; wr8_data = s.wr8_data;
      flags_we = s.flags_we; flags_mask = s.flags_mask; flags_in = s.flags_in;
      wr16_en = s.wr16_en; wr16_sel = s.wr16_sel; wr16_data = s.wr16_data;
      idu_en = s.idu_en; idu_sel = s.idu_sel; idu_dec = s.idu_dec;
      rd16_sel = s.rd16_sel; pc_we = s.pc_we; pc_data = s.pc_data; pc_inc = s.pc_inc;

      fbase = (s.wr8_en && s.wr8_sel == 3'd6) ? s.wr8_data[7:4] : m8[6][7:4];
      fnext = s.flags_we ? ((s.flags_in & s.flags_mask) | (fbase & ~s.flags_mask)) : fbase;
      e.chk  = m_valid;
      e.rd1  = m8[s.rd1_sel];
      e.rd2  = m8[s.rd2_sel];
      e.flg  = m8[6][7:4];
      e.rd16 = mpair(s.rd16_sel);
      e.pcv  = m_pc;
      e.rd1b = mbyp(s, s.rd1_sel, fnext);
      e.rd2b = mbyp(s, s.rd2_sel, fnext);
      e.flgb = fnext;
      sbq.push_back(e);

      if (s.rst) begin
         for (int i = 0; i < 8; i++) m8[i] = 8'h00;
         m_sp = 16'hFFFE;
         m_pc = 16'h0000;
         m_valid = 1'b1;
      end else begin
         n8 = m8;
         if (s.idu_en) begin
            v = s.idu_dec ? mpair(s.idu_sel) - 16'd1 : mpair(s.idu_sel) + 16'd1;
            if (s.idu_sel == 2'd3) m_sp = v;
            else begin n8[2 * s.idu_sel] = v[15:8]; n8[2 * s.idu_sel + 1] = v[7:0]; end
         end
         if (s.wr16_en) begin
            if (s.wr16_sel == 2'd3) m_sp = s.wr16_data;
            else begin n8[2 * s.wr16_sel] = s.wr16_data[15:8]; n8[2 * s.wr16_sel + 1] = s.wr16_data[7:0]; end
         end
         if (s.wr8_en && s.wr8_sel != 3'd6) n8[s.wr8_sel] = s.wr8_data;
         n8[6] = {fnext, 4'h0};
         m8 = n8;
         if (s.pc_we) m_pc = s.pc_data;
         else if (s.pc_inc) m_pc = m_pc + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic stim_t idle(input logic [2:0] r1, input logic [2:0] r2, input logic [1:0] r16);
      stim_t s;
      s = '0;
      s.rd1_sel = r1; s.rd2_sel = r2; s.rd16_sel = r16;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s = stim_t'({$urandom, $urandom, $urandom});
      s.rst = ($urandom_range(0, 31) == 0);
      return s;
   endfunction

   // Monitor: compare the DUT read ports with the oldest expectation every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.chk) begin
            check("rd1",     {8'h00, rd1_a},   {8'h00, e.rd1});
            check("rd2",     {8'h00, rd2_a},   {8'h00, e.rd2});
            check("flags",   {12'h0, flags_a}, {12'h0, e.flg});
            check("rd16",    rd16_a,           e.rd16);
            check("pc",      pc_a,             e.pcv);
            check("rd1_byp", {8'h00, rd1_b},   {8'h00, e.rd1b});
            check("rd2_byp", {8'h00, rd2_b},   {8'h00, e.rd2b});
            check("flg_byp", {12'h0, flags_b}, {12'h0, e.flgb});
            check("rd16_b",  rd16_b,           e.rd16);
            check("pc_b",    pc_b,             e.pcv);
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1'b0; rd1_sel = 3'd0; rd2_sel = 3'd0; wr8_en = 1'b0; wr8_sel = 3'd0;
      wr8_data = 8'h00; flags_we = 1'b0; flags_mask = 4'h0; flags_in = 4'h0;
      wr16_en = 1'b0; wr16_sel = 2'd0; wr16_data = 16'h0000; idu_en = 1'b0;
      idu_sel = 2'd0; idu_dec = 1'b0; rd16_sel = 2'd0; pc_we = 1'b0;
      pc_data = 16'h0000; pc_inc = 1'b0;
      @(posedge clk);
      #1;

      // Reset with every write enable active.
      s = rnd(); s.rst = 1'b1; s.wr8_en = 1'b1; s.flags_we = 1'b1; s.wr16_en = 1'b1;
      s.idu_en = 1'b1; s.pc_we = 1'b1; s.pc_inc = 1'b1; apply(s);
      // A = 3C while reading A/F/SP reset values.
      s = idle(3'd7, 3'd6, 2'd3); s.wr8_en = 1'b1; s.wr8_sel = 3'd7; s.wr8_data = 8'h3C; apply(s);
      // F = 10 via the 8-bit path.
      s = idle(3'd7, 3'd6, 2'd2); s.wr8_en = 1'b1; s.wr8_sel = 3'd6; s.wr8_data = 8'h1A; apply(s);
      // Masked flag update: expect F = F0.
      s = idle(3'd7, 3'd6, 2'd0); s.flags_we = 1'b1; s.flags_mask = 4'b1110; s.flags_in = 4'b1111; apply(s);
      // Write FF into F: low nibble must read 0.
      s = idle(3'd7, 3'd6, 2'd0); s.wr8_en = 1'b1; s.wr8_sel = 3'd6; s.wr8_data = 8'hFF; apply(s);
      s = idle(3'd6, 3'd7, 2'd3); s.wr16_en = 1'b1; s.wr16_sel = 2'd3; s.wr16_data = 16'h1234; apply(s);
      s = idle(3'd6, 3'd4, 2'd3); s.wr16_en = 1'b1; s.wr16_sel = 2'd2; s.wr16_data = 16'hFFFF; apply(s);
      // IDU wrap both ways, flags untouched.
      s = idle(3'd4, 3'd5, 2'd2); s.idu_en = 1'b1; s.idu_sel = 2'd2; apply(s);
      s = idle(3'd4, 3'd6, 2'd2); s.wr16_en = 1'b1; s.wr16_sel = 2'd3; s.wr16_data = 16'h0000; apply(s);
      s = idle(3'd6, 3'd5, 2'd3); s.idu_en = 1'b1; s.idu_sel = 2'd3; s.idu_dec = 1'b1; apply(s);
      s = idle(3'd6, 3'd4, 2'd3); s.wr16_en = 1'b1; s.wr16_sel = 2'd2; s.wr16_data = 16'h12FF; apply(s);
      // wr8 H and IDU HL together: expect AA00.
      s = idle(3'd4, 3'd5, 2'd2); s.wr8_en = 1'b1; s.wr8_sel = 3'd4; s.wr8_data = 8'hAA;
      s.idu_en = 1'b1; s.idu_sel = 2'd2; apply(s);
      // wr16 BC and wr8 C together: expect C = 55.
      s = idle(3'd4, 3'd5, 2'd2); s.wr16_en = 1'b1; s.wr16_sel = 2'd0; s.wr16_data = 16'h1234;
      s.wr8_en = 1'b1; s.wr8_sel = 3'd1; s.wr8_data = 8'h55; apply(s);
      s = idle(3'd0, 3'd1, 2'd0); s.pc_we = 1'b1; s.pc_data = 16'hFFFF; apply(s);
      s = idle(3'd0, 3'd1, 2'd0); s.pc_inc = 1'b1; apply(s);
      s = idle(3'd0, 3'd1, 2'd0); s.pc_inc = 1'b1; s.pc_we = 1'b1; s.pc_data = 16'h0150; apply(s);
      // Same-cycle forwarding of B on the bypass instance.
      s = idle(3'd0, 3'd6, 2'd0); s.wr8_en = 1'b1; s.wr8_sel = 3'd0; s.wr8_data = 8'h77;
      s.flags_we = 1'b1; s.flags_mask = 4'b0101; s.flags_in = 4'b0000; apply(s);
      s = idle(3'd0, 3'd6, 2'd1); apply(s);

      for (int i = 0; i < 600; i++) apply(rnd());
      apply(idle(3'd7, 3'd6, 2'd3));
      @(negedge clk);
      #1;
      check("sb_drain", 16'(sbq.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
